// File: rtl/riscv_hazard_unit.sv
// Hazard unit for a five-stage RISC-V pipeline: operand forwarding, load-use stalls, branch flushes.
// Optional statistics counters are built only when RISCV_HAZARD_STATS_EN is defined.
module riscv_hazard_unit #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs1D,
  input  logic [RA_W-1:0] rs2D,
  input  logic [RA_W-1:0] rs1E,
  input  logic [RA_W-1:0] rs2E,
  input  logic [RA_W-1:0] rdE,
  input  logic [RA_W-1:0] rdM,
  input  logic [RA_W-1:0] rdW,
  input  logic            regWriteM,
  input  logic            regWriteW,
  input  logic            loadE,
  input  logic            pcSrcE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            busy
`ifdef RISCV_HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
`endif
);

  typedef enum logic {IDLE, STALL} state_e;

  state_e     state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic       load_use;

  // M beats W because it holds the younger value; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (rs != '0 && rs == rdM && regWriteM)      return 2'b10;
    else if (rs != '0 && rs == rdW && regWriteW) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(rs1E);
    forwardBE = fwd_sel(rs2E);
  end

  assign load_use = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      rem_d   = 3'd0;
      flushD  = 1'b1;
      flushE  = 1'b1;
    end else if (pcSrcE) begin
      // A resolved branch kills the stalled instruction, so any pending stall is moot.
      flushD  = 1'b1;
      flushE  = 1'b1;
      state_d = IDLE;
      rem_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              rem_d   = 3'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
          rem_d  = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    rem_q   <= rem_d;
  end

  assign busy = (state_q == STALL) && !rst;

`ifdef RISCV_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (pcSrcE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Bench for riscv_hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus, each with its own expected queue.
module tb_riscv_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rwM, rwW, loadE, pcSrcE;
  } in_t;

  // Expected/observed word: {busy, stallF, stallD, flushD, flushE, forwardAE, forwardBE}
  localparam logic [8:0] Z     = 9'b0_0000_0000;
  localparam logic [8:0] STL   = 9'b0_1101_0000;
  localparam logic [8:0] STL_B = 9'b1_1101_0000;
  localparam logic [8:0] FL    = 9'b0_0011_0000;
  localparam logic [8:0] FL_B  = 9'b1_0011_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
  logic regWriteM = 1'b0, regWriteW = 1'b0, loadE = 1'b0, pcSrcE = 1'b0;

  logic stallF1, stallD1, flushD1, flushE1, busy1;
  logic stallF3, stallD3, flushD3, flushE3, busy3;
  logic [1:0] fwdA1, fwdB1, fwdA3, fwdB3;
`ifdef RISCV_HAZARD_STATS_EN
  logic [15:0] stallCnt1, flushCnt1;
  logic [1:0]  stallCnt3, flushCnt3;
`endif

  logic [8:0] exp1_q[$];
  logic [8:0] exp3_q[$];
  int checks = 0;
  int errors = 0;

  riscv_hazard_unit #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .loadE(loadE), .pcSrcE(pcSrcE), .stallF(stallF1), .stallD(stallD1),
    .flushD(flushD1), .flushE(flushE1), .forwardAE(fwdA1), .forwardBE(fwdB1),
    .busy(busy1)
`ifdef RISCV_HAZARD_STATS_EN
    , .stallCnt(stallCnt1), .flushCnt(flushCnt1)
`endif
  );

  riscv_hazard_unit #(.RA_W(5), .LOAD_LAT(3), .CNT_W(2)) u_lat3 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .loadE(loadE), .pcSrcE(pcSrcE), .stallF(stallF3), .stallD(stallD3),
    .flushD(flushD3), .flushE(flushE3), .forwardAE(fwdA3), .forwardBE(fwdB3),
    .busy(busy3)
`ifdef RISCV_HAZARD_STATS_EN
    , .stallCnt(stallCnt3), .flushCnt(flushCnt3)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [8:0] obs1();
    return {busy1, stallF1, stallD1, flushD1, flushE1, fwdA1, fwdB1};
  endfunction

  function automatic logic [8:0] obs3();
    return {busy3, stallF3, stallD3, flushD3, flushE3, fwdA3, fwdB3};
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic rwm, input logic [4:0] rdw,
                                           input logic rww);
    if (rs != 5'd0 && rs == rdm && rwm) return 2'b10;
    if (rs != 5'd0 && rs == rdw && rww) return 2'b01;
    return 2'b00;
  endfunction

  // Driver: applies one cycle of inputs and records what each instance must produce.
  task automatic drive(input in_t v, input logic [8:0] e1, input logic [8:0] e3);
    rst = v.rst; rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW; regWriteM = v.rwM; regWriteW = v.rwW;
    loadE = v.loadE; pcSrcE = v.pcSrcE;
    exp1_q.push_back(e1);
    exp3_q.push_back(e3);
  endtask

  task automatic test_reset();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 3; i++) begin
      v = '0; v.rdM = 5; v.rwM = 1'b1; v.rs1E = 5;
      v.rst = (i < 2);
      e1 = (i < 2) ? (FL | 9'b0_0000_1000) : 9'b0_0000_1000;
      e3 = e1;
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL reset lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL reset lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 11; i++) begin
      v = '0;
      case (i)
        0: begin v.rdM = 5; v.rwM = 1; v.rdW = 5; v.rwW = 1; v.rs1E = 5; v.rs2E = 5; e1 = 9'b0_0000_1010; end
        1: begin v.rdM = 5; v.rwM = 0; v.rdW = 5; v.rwW = 1; v.rs1E = 5; v.rs2E = 5; e1 = 9'b0_0000_0101; end
        2: begin v.rdM = 0; v.rwM = 1; v.rdW = 5; v.rwW = 1; v.rs1E = 0; v.rs2E = 5; e1 = 9'b0_0000_0001; end
        default: begin
          v.rdM = 5'($urandom_range(0, 3)); v.rdW = 5'($urandom_range(0, 3));
          v.rs1E = 5'($urandom_range(0, 3)); v.rs2E = 5'($urandom_range(0, 3));
          v.rwM = 1'($urandom_range(0, 1)); v.rwW = 1'($urandom_range(0, 1));
          v.rs1D = 5'($urandom_range(0, 31)); v.rs2D = 5'($urandom_range(0, 31));
          e1 = {5'b0, fwd_model(v.rs1E, v.rdM, v.rwM, v.rdW, v.rwW),
                      fwd_model(v.rs2E, v.rdM, v.rwM, v.rdW, v.rwW)};
        end
      endcase
      e3 = e1;
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL forward lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL forward lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 5; i++) begin
      v = '0; e1 = Z; e3 = Z;
      if (i == 0) begin v.loadE = 1; v.rdE = 3; v.rs2D = 3; e1 = STL; e3 = STL; end
      else if (i < 3) e3 = STL_B;
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL load_use lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL load_use lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_abort();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 3; i++) begin
      v = '0; e1 = Z; e3 = Z;
      case (i)
        0: begin v.loadE = 1; v.rdE = 3; v.rs2D = 3; e1 = STL; e3 = STL; end
        1: begin v.pcSrcE = 1; e1 = FL; e3 = FL_B; end
        default: ;
      endcase
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL branch_abort lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL branch_abort lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_and_branch();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 3; i++) begin
      v = '0; e1 = Z; e3 = Z;
      case (i)
        0: begin v.loadE = 1; v.rdE = 0; v.rs1D = 0; v.rs2D = 0; end
        1: begin v.loadE = 1; v.rdE = 9; v.rs1D = 9; v.pcSrcE = 1; e1 = FL; e3 = FL; end
        default: ;
      endcase
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL x0_branch lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL x0_branch lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 3; i++) begin
      v = '0; e1 = Z; e3 = Z;
      case (i)
        0: begin v.loadE = 1; v.rdE = 4; v.rs1D = 4; e1 = STL; e3 = STL; end
        1: begin v.rst = 1; e1 = FL; e3 = FL; end
        default: ;
      endcase
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL rst_mid_stall lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL rst_mid_stall lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

  // Reset, two load-use events with the second arriving right as the first stall ends, then a branch.
  task automatic test_back_to_back();
    in_t v;
    logic [8:0] e1, e3;
    for (int i = 0; i < 9; i++) begin
      v = '0; e1 = Z; e3 = Z;
      case (i)
        0: begin v.rst = 1; e1 = FL; e3 = FL; end
        1, 4: begin v.loadE = 1; v.rdE = 7; v.rs1D = 7; e1 = STL; e3 = STL; end
        2, 3, 5, 6: e3 = STL_B;
        7: begin v.pcSrcE = 1; e1 = FL; e3 = FL; end
        default: ;
      endcase
      drive(v, e1, e3);
      @(negedge clk);
      e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
      if (obs1() !== e1) begin errors++; $display("FAIL back_to_back lat1 c%0d: got %b exp %b", i, obs1(), e1); end
      if (obs3() !== e3) begin errors++; $display("FAIL back_to_back lat3 c%0d: got %b exp %b", i, obs3(), e3); end
      @(posedge clk); #1;
    end
  endtask

`ifdef RISCV_HAZARD_STATS_EN
  task automatic test_stats();
    in_t v;
    logic [8:0] e1, e3;
    test_back_to_back();
    checks += 4;
    if (stallCnt1 !== 16'd2) begin errors++; $display("FAIL stallCnt lat1: got %0d exp 2", stallCnt1); end
    if (stallCnt3 !== 2'd3) begin errors++; $display("FAIL stallCnt lat3 sat: got %0d exp 3", stallCnt3); end
    if (flushCnt1 !== 16'd1) begin errors++; $display("FAIL flushCnt lat1: got %0d exp 1", flushCnt1); end
    if (flushCnt3 !== 2'd1) begin errors++; $display("FAIL flushCnt lat3: got %0d exp 1", flushCnt3); end
    v = '0; v.rst = 1;
    drive(v, FL, FL);
    @(negedge clk);
    e1 = exp1_q.pop_front(); e3 = exp3_q.pop_front(); checks += 2;
    if (obs1() !== e1) begin errors++; $display("FAIL stats_rst lat1: got %b exp %b", obs1(), e1); end
    if (obs3() !== e3) begin errors++; $display("FAIL stats_rst lat3: got %b exp %b", obs3(), e3); end
    @(posedge clk); #1;
    checks += 2;
    if (stallCnt3 !== 2'd0) begin errors++; $display("FAIL stallCnt clear: got %0d exp 0", stallCnt3); end
    if (flushCnt1 !== 16'd0) begin errors++; $display("FAIL flushCnt clear: got %0d exp 0", flushCnt1); end
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_abort();
    test_x0_and_branch();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef RISCV_HAZARD_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d left exp 0", exp1_q.size(), exp3_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
